// File: rtl/hex_word_entry_if.sv
// rtl/hex_word_entry_if.sv - word offer handshake between entry block and its consumer
interface hex_word_entry_if;
  logic [15:0] word;
  logic [2:0]  digits;
  logic        valid;
  logic        ready;

  modport master (
    output word,
    output digits,
    output valid,
    input  ready
  );

  modport slave (
    input  word,
    input  digits,
    input  valid,
    output ready
  );
endinterface

// File: rtl/hex_word_entry.sv
// rtl/hex_word_entry.sv - button conditioning and nibble-wise 16-bit word entry with handshake
module hex_word_entry #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic              clear_n,
  input  logic [3:0]        nibble,
  output logic              press_pulse,
  hex_word_entry_if.master  entry
);

  // Last count value before a level change is committed: the commit edge is
  // the DEBOUNCE_CYCLES-th consecutive edge that sees synced != debounced.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ENTRY, FULL} state_t;

  // Index 0 is the entry key, index 1 is the clear key.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [DB_W-1:0]        db_cnt [2];
  logic [1:0]             db_level;
  logic [1:0]             fall;
  logic                   clear_evt;
  state_t                 state;

  assign raw         = {clear_n, key_n};
  assign press_pulse = fall[0];
  assign clear_evt   = fall[1];

  // Synchronize, debounce and detect the 1->0 transition of each button.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        sync_q[b] <= '1;
        db_cnt[b] <= '0;
      end
      db_level <= 2'b11;
      fall     <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw[b]};
        fall[b]   <= 1'b0;
        if (sync_q[b][SYNC_STAGES-1] != db_level[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            db_level[b] <= sync_q[b][SYNC_STAGES-1];
            db_cnt[b]   <= '0;
            // A commit while released means the button just went down.
            fall[b]     <= db_level[b];
          end else begin
            db_cnt[b] <= db_cnt[b] + 1'b1;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  // Entry FSM: shift nibbles in, hold the full word until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ENTRY;
      entry.word   <= 16'h0000;
      entry.digits <= 3'd0;
      entry.valid  <= 1'b0;
    end else if (clear_evt) begin
      // Clear beats both a simultaneous press and a simultaneous transfer.
      state        <= ENTRY;
      entry.word   <= 16'h0000;
      entry.digits <= 3'd0;
      entry.valid  <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (press_pulse) begin
            entry.word   <= {entry.word[11:0], nibble};
            entry.digits <= entry.digits + 3'd1;
            if (entry.digits == 3'd3) begin
              entry.valid <= 1'b1;
              state       <= FULL;
            end
          end
        end
        FULL: begin
          if (entry.valid && entry.ready) begin
            state        <= ENTRY;
            entry.word   <= 16'h0000;
            entry.digits <= 3'd0;
            entry.valid  <= 1'b0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_word_entry.sv
// tb/tb_hex_word_entry.sv - directed self-checking bench for hex_word_entry
module tb_hex_word_entry;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic       clear_n;
  logic [3:0] nibble;
  logic       press_pulse;
  int         n_assert;
  int         n_fail;
  int         lat;
  int         pulses;

  hex_word_entry_if bus ();

  hex_word_entry #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .DB_W            (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .clear_n     (clear_n),
    .nibble      (nibble),
    .press_pulse (press_pulse),
    .entry       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] w, input logic [2:0] d,
                            input logic v);
    chk({tag, "_word"}, {16'h0, bus.word}, {16'h0, w});
    chk({tag, "_digits"}, {29'h0, bus.digits}, {29'h0, d});
    chk({tag, "_valid"}, {31'h0, bus.valid}, {31'h0, v});
  endtask

  // Hold the key low 8 cycles then released 8 cycles; report latency and pulse count.
  task automatic press(input logic [3:0] n, output int l, output int p);
    nibble = n;
    key_n  = 1'b0;
    l = 0;
    p = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (press_pulse) begin
        p++;
        if (l == 0) l = i;
      end
    end
    key_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (press_pulse) p++;
    end
  endtask

  task automatic clear_press();
    clear_n = 1'b0;
    repeat (8) tick();
    clear_n = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    key_n     = 1'b1;
    clear_n   = 1'b1;
    nibble    = 4'h0;
    bus.ready = 1'b0;
    #1;
    tick();
    tick();
    reset = 1'b0;
    check_word("reset", 16'h0000, 3'd0, 1'b0);
    chk("reset_pulse", {31'h0, press_pulse}, 32'h0);

    press(4'hA, lat, pulses);
    chk("lat_A", lat, 6);
    chk("pulses_A", pulses, 1);
    check_word("entry_A", 16'h000A, 3'd1, 1'b0);
    press(4'hB, lat, pulses);
    chk("pulses_B", pulses, 1);
    check_word("entry_B", 16'h00AB, 3'd2, 1'b0);
    press(4'hC, lat, pulses);
    chk("pulses_C", pulses, 1);
    check_word("entry_C", 16'h0ABC, 3'd3, 1'b0);
    press(4'hD, lat, pulses);
    chk("pulses_D", pulses, 1);
    check_word("entry_D", 16'hABCD, 3'd4, 1'b1);

    nibble = 4'h5;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      key_n = 1'b0;
      repeat (3) begin tick(); if (press_pulse) pulses++; end
      key_n = 1'b1;
      tick();
      if (press_pulse) pulses++;
    end
    key_n = 1'b0;
    repeat (10) begin tick(); if (press_pulse) pulses++; end
    key_n = 1'b1;
    repeat (8) begin tick(); if (press_pulse) pulses++; end
    chk("bounce_pulses", pulses, 1);
    check_word("bounce_full", 16'hABCD, 3'd4, 1'b1);

    repeat (20) tick();
    press(4'hF, lat, pulses);
    chk("full_press_pulses", pulses, 1);
    check_word("hold_ready0", 16'hABCD, 3'd4, 1'b1);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    check_word("transfer", 16'h0000, 3'd0, 1'b0);

    press(4'h1, lat, pulses);
    press(4'h2, lat, pulses);
    check_word("pre_clear", 16'h0012, 3'd2, 1'b0);
    clear_press();
    check_word("clear", 16'h0000, 3'd0, 1'b0);

    press(4'h5, lat, pulses);
    check_word("pre_both", 16'h0005, 3'd1, 1'b0);
    nibble  = 4'h7;
    key_n   = 1'b0;
    clear_n = 1'b0;
    pulses  = 0;
    repeat (8) begin tick(); if (press_pulse) pulses++; end
    key_n   = 1'b1;
    clear_n = 1'b1;
    repeat (8) begin tick(); if (press_pulse) pulses++; end
    chk("both_pulses", pulses, 1);
    check_word("both_clear_wins", 16'h0000, 3'd0, 1'b0);

    press(4'h1, lat, pulses);
    press(4'h2, lat, pulses);
    press(4'h3, lat, pulses);
    check_word("pre_reset", 16'h0123, 3'd3, 1'b0);
    nibble = 4'h9;
    key_n  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_word("mid_reset", 16'h0000, 3'd0, 1'b0);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (press_pulse) lat = i;
    end
    chk("lat_after_reset", lat, 6);
    tick();
    check_word("after_reset", 16'h0009, 3'd1, 1'b0);
    key_n = 1'b1;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
